// File: rtl/mesh_pkg.sv
// Shared element/row types for the 8x8 systolic mesh datapath, used by the
// input feeder, the mesh wrapper and the output deskew collector.
package mesh_pkg;

    localparam int DIM   = 8;
    localparam int OUT_W = 19;
    localparam int IDX_W = $clog2(DIM);

    typedef logic signed [OUT_W-1:0] elem_t;
    typedef elem_t [DIM-1:0]         row_t;
    typedef logic [IDX_W-1:0]        idx_t;

    typedef struct packed {
        row_t row;
        idx_t idx;
    } row_entry_t;

    // Row position within a DIM-row tile, wrapping explicitly so a
    // non-power-of-two DIM still cycles through 0..DIM-1.
    function automatic idx_t next_idx(input idx_t cur);
        return (cur == idx_t'(DIM - 1)) ? '0 : idx_t'(cur + 1'b1);
    endfunction

endpackage

// File: rtl/mesh_row_fifo.sv
// Row FIFO behind the deskew stage: stores {row, idx} entries and exposes the
// head with a registered-state ready/valid interface.
module mesh_row_fifo
    import mesh_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  row_entry_t               push_entry,
    input  logic                     out_ready,
    output logic                     out_valid,
    output row_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    row_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic             pop;
    logic             accept;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign accept    = push & ((count_q < FULL) | pop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push & !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head     = out_valid ? mem[rd_ptr] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/mesh_out_deskew.sv
// Output-side collector for the systolic mesh: undoes the per-column skew of
// io_out_c so each row is whole in one cycle, then buffers rows for downstream.
module mesh_out_deskew
    import mesh_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [DIM*OUT_W-1:0]     in_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIM*OUT_W-1:0]     out_row,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    row_t         in_row;
    row_t         aligned_row;
    logic [DIM-2:0] valid_q;
    logic         push;
    idx_t         idx_ctr;
    row_entry_t   push_entry;
    row_entry_t   head;

    assign in_row = in_c;

    // Column j arrives j cycles after column 0, so it waits DIM-1-j cycles;
    // the last column is consumed straight from the input.
    for (genvar j = 0; j < DIM; j++) begin : g_col
        localparam int STAGES = DIM - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign aligned_row[j] = in_row[j];
        end else begin : g_delay
            elem_t stage_q [STAGES];
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int k = 0; k < STAGES; k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q[0] <= in_row[j];
                    for (int k = 1; k < STAGES; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end
            assign aligned_row[j] = stage_q[STAGES-1];
        end
    end

    // The valid strobe rides alongside column 0 so it lands with the full row.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DIM-3:0], in_valid};
        end
    end

    assign push = valid_q[DIM-2];

    // Tile position advances even for dropped rows to stay locked to the mesh.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_ctr <= '0;
        end else if (push) begin
            idx_ctr <= next_idx(idx_ctr);
        end
    end

    assign push_entry.row = aligned_row;
    assign push_entry.idx = idx_ctr;

    mesh_row_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .push_entry (push_entry),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .head       (head),
        .count      (count),
        .overflow   (overflow)
    );

    assign out_row  = head.row;
    assign out_idx  = head.idx;
    assign out_last = out_valid & (head.idx == idx_t'(DIM - 1));

endmodule

// File: doc/mesh_out_deskew.md
# mesh_out_deskew

Output-side collector for the 8x8 systolic Mesh array. It takes the column-skewed `io_out_c` results and the column-0 valid strobe, and realigns the columns so each output row is complete in one cycle. Aligned rows are buffered in a small FIFO and handed downstream over a ready/valid handshake, with a position-in-tile index. It sits between the registered mesh wrapper outputs and the accumulator/scratchpad write path.

## Interface
- `DIM`, 8, mesh columns per row.
- `OUT_W`, 19, width of one result element (two's complement).
- `DEPTH`, 8, FIFO capacity in rows; power of two, at least 2.

- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  column-0 result valid (mesh `io_out_valid_0_0`).
- `in_c`  in  DIM*OUT_W  column j result at bits `[j*OUT_W +: OUT_W]`. Column j is valid j cycles after `in_valid`.
- `out_valid`  out  1  head row available.
- `out_ready`  in  1  downstream accepts the head row this cycle.
- `out_row`  out  DIM*OUT_W  aligned row, with the same column packing as `in_c`.
- `out_idx`  out  $clog2(DIM)  row position within the current DIM-row tile.
- `out_last`  out  1  `out_idx == DIM-1` and `out_valid`.
- `count`  out  $clog2(DEPTH)+1  rows currently stored.
- `overflow`  out  1  sticky: at least one aligned row was dropped.

## Operation
- **Deskew.**
  - Column j data passes through a register delay line of DIM-1-j stages. Column DIM-1 has zero stages and is used combinationally at the push point.
  - `in_valid` passes through DIM-1 stages to form `push`.
  - When `push=1`, all delayed columns belong to the same row.
  - Delay lines shift every cycle and are never stalled, because the mesh cannot be back-pressured.
- **Row index.**
  - `idx_ctr` increments on every `push`, including dropped rows, and wraps from DIM-1 to 0.
  - Each stored row carries its `idx_ctr` value.
- **FIFO.**
  - `pop = out_valid & out_ready`.
  - `push` is accepted if `count < DEPTH`, or if `count == DEPTH` and `pop` in the same cycle.
  - Otherwise the row is discarded, `overflow` is set to 1, and `count` is unchanged.
  - Simultaneous push and pop leaves `count` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Output.**
  - `out_row` and `out_idx` show the head entry whenever `out_valid=1`.
  - They hold stable while `out_valid & !out_ready`.
  - When empty, `out_row` and `out_idx` are don't-care. The RTL drives them to 0.
- **Arithmetic.** Elements are pass-through with no width change and no sign manipulation.
- **Reset.**
  - `RST=0` clears, immediately and asynchronously: delay lines (data and valid), `idx_ctr`, pointers, `count`, `overflow`, `out_valid`, `out_row`, `out_idx`, `out_last`.
  - Rows in flight or stored at reset are lost. No stale row appears after release.
  - `overflow` is cleared only by reset.

## Timing
- `in_valid` at cycle t causes `push` at cycle t+DIM-1.
- If the FIFO is empty, `out_valid=1` from cycle t+DIM onward (registered FIFO output). End-to-end latency is DIM cycles, i.e. 8 at default.
- `count` updates the cycle after a push/pop.
- `overflow` rises the cycle after the dropped push.
- Throughput: one row per cycle in and out, sustained, when `out_ready=1`.
- Handshake: data must not change while `out_valid=1` and `out_ready=0`. `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package `mesh_pkg`: `DIM`, `OUT_W`, `typedef logic signed [OUT_W-1:0] elem_t`, `typedef elem_t [DIM-1:0] row_t`. The same package is used by the mesh wrapper and the input-side feeder.
- Sub-module `mesh_row_fifo`: a synchronous FIFO of `{row_t, idx}` entries with the DEPTH/`count`/full-with-pop rule above.
- Deskew delay lines live in `mesh_out_deskew` itself, generated per column.

## Test plan
- **Single row.** `in_valid` at cycle 0, column j = j+1, each presented at cycle j, `out_ready=1` → `out_valid` at cycle 8 only, `out_row` columns = 1..8, `out_idx=0`, `out_last=0`.
- **Full tile.** 8 back-to-back rows, row r column j = 16r+j, `out_ready=1` → outputs on cycles 8–15 with matching values, `out_idx` 0..7, `out_last=1` only on the 8th, `count` ≤ 1.
- **Overflow.** `out_ready=0`, 9 rows → `count=8`, 9th row dropped, `overflow=1` one cycle after its push. Then `out_ready=1` → exactly rows 0–7 drain, and `overflow` stays 1.
- **Full with simultaneous pop.** FIFO full, pop and push in the same cycle → no overflow, `count=8`, new row appears last.
- **Sign pass-through.** A column value of -1 (`0x7FFFF`) and -2^18 (`0x40000`) come out bit-exact.
- **Mid-stream reset.** Assert `RST=0` mid-stream → all outputs are 0 immediately. After release with no new input, `out_valid` stays 0 for 20 cycles. A new row then gets `out_idx=0`.
